// File: rtl/dispatch_pkg.sv
// Shared state encoding and default sizing for the matrix block dispatcher.
package dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_NUM_CU      = 4;
  localparam int DEF_INDEX_WIDTH = 8;
  localparam int DEF_MAX_MU_LOG  = 8;

endpackage

// File: rtl/matrix_dispatcher_cu_select.sv
// Lowest-index-first grant over the mask of free worker units.
module cu_select
  import dispatch_pkg::*;
#(
  parameter int NUM_CU = DEF_NUM_CU
) (
  input  logic [NUM_CU-1:0] free,
  output logic [NUM_CU-1:0] grant,
  output logic              any_free
);

  // x & -x keeps only the lowest set bit.
  assign grant    = free & (~free + NUM_CU'(1));
  assign any_free = |free;

endmodule

// File: rtl/matrix_dispatcher.sv
// Row-major block dispatcher feeding NUM_CU workers for one C-matrix job.
// DISPATCH_PERF_COUNT_EN adds the o_Cycle_Count job-length counter.
module matrix_dispatcher
  import dispatch_pkg::*;
#(
  parameter int NUM_CU      = DEF_NUM_CU,
  parameter int index_width = DEF_INDEX_WIDTH,
  parameter int max_mu_log  = DEF_MAX_MU_LOG
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic                   i_Start,
  input  logic [max_mu_log-1:0]  i_mu,
  output logic [index_width-1:0] o_Row_Index,
  output logic [index_width-1:0] o_Column_Index,
  output logic [NUM_CU-1:0]      o_Indexes_Ready,
  input  logic [NUM_CU-1:0]      i_Result_Ready,
  output logic                   o_Busy,
`ifdef DISPATCH_PERF_COUNT_EN
  output logic [31:0]            o_Cycle_Count,
`endif
  output logic                   o_Done
);

  localparam int MW = index_width + 1;
  localparam int WW = (max_mu_log > MW) ? max_mu_log : MW;
  localparam logic [WW-1:0] MU_CAP = WW'(1) << index_width;

  state_t                 state;
  logic [NUM_CU-1:0]      busy;
  logic [NUM_CU-1:0]      grant;
  logic                   any_free;
  logic [index_width-1:0] row;
  logic [index_width-1:0] col;
  logic [MW-1:0]          mu_q;
  logic [MW-1:0]          mu_last;
  logic [MW-1:0]          mu_sat;
  logic [WW-1:0]          mu_ext;
  logic                   row_end;
  logic                   col_end;

  cu_select #(
    .NUM_CU(NUM_CU)
  ) u_sel (
    .free    (~busy),
    .grant   (grant),
    .any_free(any_free)
  );

  // mu is one bit wider than the indexes so 2^index_width fits.
  assign mu_ext  = WW'(i_mu);
  assign mu_sat  = (mu_ext > MU_CAP) ? MW'(MU_CAP) : MW'(mu_ext);
  assign mu_last = mu_q - MW'(1);
  assign col_end = ({1'b0, col} == mu_last);
  assign row_end = ({1'b0, row} == mu_last);

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state           <= IDLE;
      busy            <= '0;
      row             <= '0;
      col             <= '0;
      mu_q            <= '0;
      o_Indexes_Ready <= '0;
      o_Row_Index     <= '0;
      o_Column_Index  <= '0;
      o_Busy          <= 1'b0;
      o_Done          <= 1'b0;
    end else begin
      o_Indexes_Ready <= '0;
      o_Done          <= 1'b0;
      busy            <= busy & ~i_Result_Ready;
      unique case (state)
        IDLE: begin
          if (i_Start) begin
            mu_q   <= mu_sat;
            row    <= '0;
            col    <= '0;
            o_Busy <= 1'b1;
            state  <= (mu_sat == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (any_free) begin
            o_Indexes_Ready <= grant;
            o_Row_Index     <= row;
            o_Column_Index  <= col;
            busy            <= (busy & ~i_Result_Ready) | grant;
            if (col_end) begin
              col <= '0;
              row <= row + index_width'(1);
              if (row_end) state <= DRAIN;
            end else begin
              col <= col + index_width'(1);
            end
          end
        end
        DRAIN: begin
          if (busy == '0) state <= DONE;
        end
        DONE: begin
          o_Done <= 1'b1;
          o_Busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef DISPATCH_PERF_COUNT_EN
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      o_Cycle_Count <= '0;
    end else if (state == IDLE && i_Start) begin
      o_Cycle_Count <= '0;
    end else if (o_Busy) begin
      o_Cycle_Count <= o_Cycle_Count + 32'd1;
    end
  end
`endif

endmodule
